// File: rtl/fpcvt_serial_loader.sv
// Serial-to-parallel sample loader feeding the 13-bit float converter.
// Shifts a frame in MSB first, holds the word under valid/ready, and flags
// aborted frames (restart, inter-bit timeout) and starts dropped while full.
module fpcvt_serial_loader #(
    parameter int unsigned DATA_W  = 13,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin_start,
    input  logic              sin_valid,
    input  logic              sin_bit,
    output logic [DATA_W-1:0] d_out,
    output logic              d_valid,
    input  logic              d_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [TMR_W-1:0]  idle_tmr, idle_tmr_nxt, tmr_inc;
    logic [DATA_W-1:0] sreg, sreg_nxt, shift_word;
    logic [DATA_W-1:0] d_out_nxt;
    logic              d_valid_nxt, busy_nxt, frame_err_nxt, overrun_nxt;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            idle_tmr  <= '0;
            sreg      <= '0;
            d_out     <= '0;
            d_valid   <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            idle_tmr  <= idle_tmr_nxt;
            sreg      <= sreg_nxt;
            d_out     <= d_out_nxt;
            d_valid   <= d_valid_nxt;
            busy      <= busy_nxt;
            frame_err <= frame_err_nxt;
            overrun   <= overrun_nxt;
        end
    end

    // Next-state, datapath and pulse decode
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        idle_tmr_nxt  = idle_tmr;
        sreg_nxt      = sreg;
        d_out_nxt     = d_out;
        d_valid_nxt   = d_valid;
        frame_err_nxt = 1'b0;
        overrun_nxt   = 1'b0;
        shift_word    = {sreg[DATA_W-2:0], sin_bit};
        tmr_inc       = idle_tmr + TMR_W'(1);

        case (state)
            IDLE: begin
                if (sin_start) begin
                    state_nxt    = SHIFT;
                    bit_cnt_nxt  = '0;
                    idle_tmr_nxt = '0;
                    sreg_nxt     = '0;
                end
            end
            SHIFT: begin
                if (sin_start) begin
                    // restart discards the partial frame and any same-cycle bit
                    bit_cnt_nxt   = '0;
                    idle_tmr_nxt  = '0;
                    sreg_nxt      = '0;
                    frame_err_nxt = 1'b1;
                end else if (sin_valid) begin
                    sreg_nxt     = shift_word;
                    idle_tmr_nxt = '0;
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        d_out_nxt   = shift_word;
                        d_valid_nxt = 1'b1;
                        state_nxt   = HOLD;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end else begin
                    idle_tmr_nxt = tmr_inc;
                    if (tmr_inc == TMR_W'(TIMEOUT)) begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = IDLE;
                    end
                end
            end
            HOLD: begin
                if (d_ready) begin
                    d_valid_nxt = 1'b0;
                    if (sin_start) begin
                        // back-to-back frame: transfer and restart in one edge
                        state_nxt    = SHIFT;
                        bit_cnt_nxt  = '0;
                        idle_tmr_nxt = '0;
                        sreg_nxt     = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (sin_start) begin
                    overrun_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule
